// File: rtl/trainer_pkg.sv
// trainer_pkg: shared FSM state type and index constants
// for the trainer input sequencer.
package trainer_pkg;

   localparam int NUM_GATES = 7;
   localparam int NUM_COMBOS = 4;
   localparam logic [2:0] SEL_MAX = 3'd6;

   typedef enum logic [1:0] {
      S_MANUAL,
      S_AUTO,
      S_CAPTURE,
      S_ADVANCE
   } state_t;

   // Outer gate counter, wrapping after the last gate.
   function automatic logic [2:0] next_sel(input logic [2:0] s);
      return (s == SEL_MAX) ? 3'd0 : s + 3'd1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and
// one-cycle pulse on a debounced 0->1 transition.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;
   logic          flip;

   // Last of the required run of samples that disagree with level.
   assign flip = (sync2 != level) &&
                 (cnt == CW'(DEBOUNCE_CYCLES - 1));

   // Synchronize, count the stable run, flip level and pulse on rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         press <= flip && sync2;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (flip) begin
            cnt   <= '0;
            level <= sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/trainer_input_sequencer.sv
// trainer_input_sequencer: steps {sel,a,b} through all gate/input
// combos and publishes truth-table rows. Auto mode: TRAINER_SEQ_AUTO_EN.
module trainer_input_sequencer #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int AUTO_PERIOD = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_step,
   input  logic       btn_mode,
   input  logic       y_in,
   output logic       a,
   output logic       b,
   output logic [2:0] sel,
   output logic [3:0] row_bits,
   output logic [2:0] row_sel,
   output logic       row_valid,
   output logic       auto_mode
);

   import trainer_pkg::*;

   localparam logic [1:0] LAST_AB = 2'(NUM_COMBOS - 1);

   state_t     state;
   logic [3:0] shadow;
   logic [1:0] ab;
   logic       step_press;
   logic       mode_press;
   logic       tick;

   assign ab = {a, b};

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_step (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_step),
      .press(step_press)
   );

`ifdef TRAINER_SEQ_AUTO_EN
   localparam int TW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

   logic [TW-1:0] timer;
   logic          enter_auto;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_mode (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_mode),
      .press(mode_press)
   );

   assign tick = (state == S_AUTO) &&
                 (timer == TW'(AUTO_PERIOD - 1));

   assign enter_auto =
      ((state == S_MANUAL) && mode_press) ||
      ((state == S_ADVANCE) && (auto_mode ^ mode_press));

   // Auto-step timer: restarts on entry to AUTO, runs only in AUTO.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer <= '0;
      end else if (enter_auto) begin
         timer <= '0;
      end else if (state == S_AUTO) begin
         timer <= tick ? '0 : timer + 1'b1;
      end
   end
`else
   localparam int unused_period = AUTO_PERIOD;
   logic unused_mode;

   assign unused_mode = btn_mode;
   assign mode_press  = 1'b0;
   assign tick        = 1'b0;
`endif

   // Step FSM: wait for a step, capture y, then advance the index.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_MANUAL;
         a         <= 1'b0;
         b         <= 1'b0;
         sel       <= 3'd0;
         shadow    <= 4'd0;
         row_bits  <= 4'd0;
         row_sel   <= 3'd0;
         row_valid <= 1'b0;
         auto_mode <= 1'b0;
      end else begin
         row_valid <= 1'b0;
         if (mode_press) begin
            auto_mode <= ~auto_mode;
         end
         unique case (state)
            S_MANUAL: begin
               if (mode_press) begin
                  state <= S_AUTO;
               end else if (step_press) begin
                  state <= S_CAPTURE;
               end
            end
            S_AUTO: begin
               if (mode_press) begin
                  state <= S_MANUAL;
               end else if (tick) begin
                  state <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               shadow[ab] <= y_in;
               state      <= S_ADVANCE;
            end
            S_ADVANCE: begin
               if (ab == LAST_AB) begin
                  a         <= 1'b0;
                  b         <= 1'b0;
                  sel       <= next_sel(sel);
                  row_bits  <= shadow;
                  row_sel   <= sel;
                  row_valid <= 1'b1;
               end else begin
                  {a, b} <= ab + 2'd1;
               end
               // A mode press landing here decides the return state.
               state <= (auto_mode ^ mode_press) ? S_AUTO : S_MANUAL;
            end
            default: state <= S_MANUAL;
         endcase
      end
   end

endmodule

// File: tb/tb_trainer_input_sequencer.sv
// tb_trainer_input_sequencer: random and directed stimulus checked
// every cycle against a behavioural model of the sequencer.
module tb_trainer_input_sequencer;

   localparam int DB = 4;
   localparam int AP = 8;
`ifdef TRAINER_SEQ_AUTO_EN
   localparam bit AUTO_EN = 1'b1;
`else
   localparam bit AUTO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_step = 1'b0;
   logic       btn_mode = 1'b0;
   logic       y_in;
   logic       a;
   logic       b;
   logic [2:0] sel;
   logic [3:0] row_bits;
   logic [2:0] row_sel;
   logic       row_valid;
   logic       auto_mode;

   int checks = 0;
   int errors = 0;

   trainer_input_sequencer #(
      .DEBOUNCE_CYCLES(DB),
      .AUTO_PERIOD(AP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_step (btn_step),
      .btn_mode (btn_mode),
      .y_in     (y_in),
      .a        (a),
      .b        (b),
      .sel      (sel),
      .row_bits (row_bits),
      .row_sel  (row_sel),
      .row_valid(row_valid),
      .auto_mode(auto_mode)
   );

   always #5 clk = ~clk;

   // Gate selector stand-in.
   function automatic logic gate(input logic [2:0] s,
                                 input logic x, input logic z);
      case (s)
         3'd0: return x & z;
         3'd1: return x | z;
         3'd2: return ~(x & z);
         3'd3: return ~(x | z);
         3'd4: return x ^ z;
         3'd5: return ~(x ^ z);
         default: return ~x;
      endcase
   endfunction

   function automatic logic [3:0] truth(input int s);
      logic [3:0] t;
      logic [1:0] i2;
      for (int i = 0; i < 4; i++) begin
         i2 = 2'(i);
         t[i] = gate(3'(s), i2[1], i2[0]);
      end
      return t;
   endfunction

   assign y_in = gate(sel, a, b);

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t",
                  name, act, exp, $time);
      end
   endtask

   // Inputs as seen by the DUT at each rising edge.
   bit         started = 0;
   bit         rst_q;
   logic [1:0] raw_q;
   int         cyc = 0;

   always @(posedge clk) begin
      started = 1;
      rst_q   = rst;
      raw_q   = {btn_mode, btn_step};
      cyc++;
   end

   // Model state.
   logic [1:0] s1, s2, lvl, pls;
   logic [1:0] hist[$];
   int         flip_pos[2];
   int         m_idx, m_busy, m_run;
   bit         m_amode, m_rv, mode_hit;
   logic [3:0] m_rbits;
   logic [2:0] m_rsel;
   logic [23:0] exp_v, act_v;

   // Observation used by directed literal checks.
   int         rv_cnt = 0;
   int         rsel_q[$];
   int         chg[$];
   logic [4:0] prev_idx = 5'd0;

   always @(negedge clk) begin
      if (started) begin
         if (rst_q) begin
            s1 = 0; s2 = 0; lvl = 0; pls = 0;
            hist.delete();
            flip_pos[0] = 0; flip_pos[1] = 0;
            m_idx = 0; m_busy = 0; m_run = 0;
            m_amode = 0; m_rv = 0; m_rbits = 0; m_rsel = 0;
         end else begin
            // Step engine reacts to the pulses of the previous cycle.
            m_rv = 0;
            mode_hit = 0;
            if (pls[1] && AUTO_EN) begin
               m_amode = !m_amode;
               mode_hit = 1;
               if (m_busy == 0) m_run = 0;
            end
            if (m_busy > 0) begin
               m_busy--;
               if (m_busy == 0) begin
                  if (m_idx % 4 == 3) begin
                     m_rv = 1;
                     m_rbits = truth(m_idx / 4);
                     m_rsel = 3'(m_idx / 4);
                  end
                  m_idx = (m_idx + 1) % 28;
                  m_run = 0;
               end
            end else if (!mode_hit) begin
               if (!m_amode) begin
                  if (pls[0]) m_busy = 2;
               end else if (m_run == AP - 1) begin
                  m_busy = 2;
                  m_run = 0;
               end else begin
                  m_run++;
               end
            end
            // Debounce: flip after DB trailing samples all disagree.
            hist.push_back(s2);
            s2 = s1;
            s1 = raw_q;
            for (int k = 0; k < 2; k++) begin
               pls[k] = 0;
               if (hist.size() - flip_pos[k] >= DB) begin
                  bit all_diff;
                  all_diff = 1;
                  for (int j = hist.size() - DB; j < hist.size(); j++)
                     if (hist[j][k] == lvl[k]) all_diff = 0;
                  if (all_diff) begin
                     lvl[k] = !lvl[k];
                     pls[k] = lvl[k];
                     flip_pos[k] = hist.size();
                  end
               end
            end
         end
         exp_v = {12'd0, m_idx[1], m_idx[0], 3'(m_idx / 4), m_rv,
                  m_rbits, m_rsel, m_amode};
         act_v = {12'd0, a, b, sel, row_valid, row_bits, row_sel,
                  auto_mode};
         check("outputs", act_v, exp_v);
         if (row_valid === 1'b1) begin
            rv_cnt++;
            rsel_q.push_back(int'(row_sel));
         end
         if ({sel, a, b} !== prev_idx) begin
            chg.push_back(cyc);
            prev_idx = {sel, a, b};
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      rv_cnt = 0;
      rsel_q.delete();
      chg.delete();
   endtask

   task automatic press_step();
      btn_step = 1'b1;
      tick(12);
      btn_step = 1'b0;
      tick(12);
   endtask

   initial begin
      int n, m, guard;
      // Reset and idle.
      tick(2);
      rst = 1'b0;
      check("reset_out", {a, b, sel, row_bits, row_sel, row_valid,
                          auto_mode}, 0);
      rv_cnt = 0;
      tick(20);
      check("idle_rv", rv_cnt, 0);

      // Bouncing button, then a clean hold.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         btn_step = ~btn_step;
         tick(2);
      end
      press_step();
      check("bounce_idx", {sel, a, b}, 5'd1);
      check("bounce_chg", chg.size(), 1);

      // One manual row of the AND gate.
      do_reset();
      repeat (4) press_step();
      check("row_cnt", rv_cnt, 1);
      check("row_bits", row_bits, 4'b1000);
      check("row_sel", row_sel, 0);
      check("row_idx", {sel, a, b}, 5'b00100);

      // Full wrap through all gates.
      do_reset();
      repeat (28) press_step();
      check("wrap_cnt", rv_cnt, 7);
      for (int i = 0; i < rsel_q.size(); i++)
         check("wrap_sel", rsel_q[i], i);
      check("wrap_idx", {sel, a, b}, 5'd0);
      check("wrap_bits", row_bits, 4'b0011);

      // Reset in the middle of a row.
      do_reset();
      repeat (2) press_step();
      do_reset();
      repeat (4) press_step();
      check("mid_cnt", rv_cnt, 1);
      check("mid_sel", row_sel, 0);
      check("mid_bits", row_bits, 4'b1000);

`ifdef TRAINER_SEQ_AUTO_EN
      // Auto stepping, ignored step presses, mode press mid-CAPTURE.
      do_reset();
      btn_mode = 1'b1;
      tick(12);
      btn_mode = 1'b0;
      tick(2);
      check("auto_on", auto_mode, 1);
      chg.delete();
      press_step();
      press_step();
      check("auto_steps", chg.size() >= 3, 1);
      for (int i = 1; i < chg.size(); i++)
         check("auto_gap", chg[i] - chg[i-1], AP + 2);
      n = chg.size();
      guard = 0;
      while (chg.size() == n && guard < 30) begin
         tick(1);
         guard++;
      end
      check("auto_sync", chg.size() > n, 1);
      tick(1);
      btn_mode = 1'b1;
      m = chg.size();
      tick(12);
      btn_mode = 1'b0;
      tick(40);
      check("mode_off", auto_mode, 0);
      check("last_step", chg.size() - m, 1);
`endif

      // Random buttons and occasional resets.
      do_reset();
      for (int i = 0; i < 250; i++) begin
         btn_step = 1'($urandom_range(0, 1));
         btn_mode = AUTO_EN && ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 49) == 0) begin
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
         end
         tick($urandom_range(1, 10));
      end
      btn_step = 1'b0;
      btn_mode = 1'b0;
      tick(30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/trainer_input_sequencer.md
# trainer_input_sequencer

Upstream stimulus stage for the digital logic trainer gate selector. It debounces the two front-panel buttons and drives the selector's `a`, `b` and `sel` inputs. It steps through all 28 input/gate combinations, either manually or on an automatic timer. It samples the selector's output `y` back in and publishes each gate's completed 4-entry truth-table row.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: number of consecutive stable synchronized samples a button needs before its debounced level changes.
- `AUTO_PERIOD`, default 1000: number of cycles between auto-mode steps.

Ports:
- `clk`, in, 1: single clock. All state is registered on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `btn_step`, in, 1: raw asynchronous step button, active high.
- `btn_mode`, in, 1: raw asynchronous mode button, active high.
- `y_in`, in, 1: output `y` of the gate selector.
- `a`, out, 1: gate input A. Registered.
- `b`, out, 1: gate input B. Registered.
- `sel`, out, 3: gate select, valid range 0..6. Registered.
- `row_bits`, out, 4: last completed truth-table row. Bit i holds `y` for `{a,b}`=i.
- `row_sel`, out, 3: gate index that `row_bits` belongs to.
- `row_valid`, out, 1: one-cycle pulse when `row_bits`/`row_sel` update.
- `auto_mode`, out, 1: 1 = auto stepping, 0 = manual.

## Operation
**Buttons**
- Each button passes through a 2-flop synchronizer, then a stability counter.
- The debounced level flips after `DEBOUNCE_CYCLES` consecutive samples that differ from it. Any bounce resets the counter.
- A debounced 0→1 transition produces a one-cycle press pulse.

**Index**
- `{sel, a, b}` forms the index. `{a,b}` is the inner counter (0..3); `sel` is the outer counter (0..6).
- Advancing from `{a,b}`=3 sets `{a,b}`=0 and increments `sel`.
- Advancing from `sel`=6, `{a,b}`=3 wraps to `sel`=0, `{a,b}`=0.
- `sel`=7 is never driven.

**FSM states:** MANUAL, AUTO, CAPTURE, ADVANCE.
- MANUAL: a step press moves to CAPTURE.
- AUTO: the timer tick moves to CAPTURE. Step presses are ignored.
- CAPTURE (1 cycle): sample `y_in` into shadow bit `{a,b}`.
- ADVANCE (1 cycle): update the index.
  - If the old `{a,b}` was 3, copy shadow to `row_bits`, copy old `sel` to `row_sel`, and pulse `row_valid`.
  - Then return to MANUAL or AUTO according to `auto_mode`.
- Mode press: toggles `auto_mode` in any state. The new mode takes effect on the next return from ADVANCE, or immediately when in MANUAL/AUTO.
- Step presses and ticks arriving during CAPTURE/ADVANCE are dropped.

**Auto timer**
- Counts 0..`AUTO_PERIOD`-1 only while in the AUTO state. The tick is issued at the terminal count.
- Clears to 0 on entry to AUTO and holds while in any other state.

## Timing
- Step path:
  - Raw press → 2 synchronizer cycles → `DEBOUNCE_CYCLES` stable samples → press pulse (cycle N).
  - N+1: state is CAPTURE.
  - N+2: state is ADVANCE.
  - N+3: new `a`/`b`/`sel` visible; `row_valid`/`row_bits`/`row_sel` also visible if a row completed.
- `y_in` is sampled at the end of CAPTURE, at least 2 cycles after the last index change. The combinational gate has settled by then.
- Auto mode: one step every `AUTO_PERIOD`+2 cycles (timer period plus CAPTURE and ADVANCE).
- Reset values:
  - `a`=`b`=0, `sel`=0.
  - `row_bits`=0, `row_sel`=0, `row_valid`=0, `auto_mode`=0.
  - State MANUAL; shadow, timer and debounce counters 0; debounced levels 0.
- Reset mid-operation: the partial row is discarded and no `row_valid` is produced.
- A button held through reset yields one press pulse after `DEBOUNCE_CYCLES`+2 cycles.

## Configuration
Macro: `TRAINER_SEQ_AUTO_EN`.
- Defined: auto mode, mode button and timer are present, as described above.
- Undefined:
  - Timer and mode debouncer are not built.
  - `btn_mode` is ignored and `auto_mode` is tied 0.
  - The FSM never enters AUTO; `AUTO_PERIOD` has no effect.

## Structure
- Package `trainer_pkg` holds:
  - the FSM state enum;
  - `NUM_GATES`=7 and `NUM_COMBOS`=4;
  - `SEL_MAX`=3'd6.
- Sub-module `btn_debounce` (synchronizer, stability counter and rising-edge pulse) is instantiated once per button.

## Test plan
Use `DEBOUNCE_CYCLES`=4, `AUTO_PERIOD`=8, with a behavioural gate model driving `y_in`.
1. Reset: assert `rst` for 2 cycles → all outputs 0, `auto_mode`=0, no `row_valid` for 20 idle cycles.
2. Bounce: toggle `btn_step` every 2 cycles for 20 cycles, then hold high → exactly one step; `{sel,a,b}` goes 0→1 at pulse+3.
3. Manual row: 4 clean presses with gate 0 = AND → `row_valid` pulses once, `row_bits`=4'b1000, `row_sel`=0; index = `sel` 1, ab 0.
4. Wrap: 28 presses with full model → 7 `row_valid` pulses with `row_sel` 0..6 in order; final index `sel`=0, `a`=0, `b`=0.
5. Auto (macro on): mode press → `auto_mode`=1; steps every 10 cycles. Step presses ignored. A mode press mid-CAPTURE returns the FSM to MANUAL after ADVANCE.
6. Reset mid-row: reset after 2 steps, then 4 presses → single `row_valid` with `row_sel`=0; no stale shadow bits.
